// File: rtl/perceptron_learner.sv
// perceptron_learner: single-layer perceptron with a serial MAC datapath.
// Online learning is built only when PERCEPTRON_TRAIN_EN is defined.
module perceptron_learner #(
    parameter int N  = 8,
    parameter int XW = 8,
    parameter int WW = 8,
    localparam int CW = $clog2(N + 1),
    localparam int AW = XW + WW + CW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*XW-1:0] in_x,
    input  logic            in_target,
    input  logic            in_train,
    input  logic            wr_en,
    input  logic [CW-1:0]   wr_addr,
    input  logic [WW-1:0]   wr_data,
    output logic            out_valid,
    output logic            out_class,
    output logic [AW-1:0]   out_sum,
    output logic            busy
);
    localparam int PW = WW + XW + 1;

    typedef enum logic [1:0] {IDLE, MAC, DECIDE, UPDATE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic [WW-1:0] w [N];
    logic [WW-1:0] bias;
    logic [XW-1:0] x_q [N];
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;
    logic [WW-1:0] w_sel;
    logic [XW-1:0] x_sel;
    logic [PW-1:0] prod;

`ifdef PERCEPTRON_TRAIN_EN
    localparam int SW = WW + XW + 1;
    localparam logic signed [SW-1:0] SMAX = SW'(2 ** (WW - 1) - 1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;

    logic target_q;
    logic train_q;

    function automatic logic [WW-1:0] sat_step(
        input logic [WW-1:0] a,
        input logic [XW-1:0] b,
        input logic          up
    );
        logic signed [SW-1:0] ea;
        logic signed [SW-1:0] eb;
        logic signed [SW-1:0] s;
        ea = {{(SW - WW){a[WW-1]}}, a};
        eb = {{(SW - XW){1'b0}}, b};
        s = up ? ea + eb : ea - eb;
        if (s > SMAX) s = SMAX;
        else if (s < SMIN) s = SMIN;
        return s[WW-1:0];
    endfunction
`else
    logic unused_train;
    assign unused_train = ^{in_train, in_target};
`endif

    // MAC step k works on element k-1; UPDATE step j on element j.
    always_comb begin
        idx = (state == MAC) ? cnt - CW'(1) : cnt;
        w_sel = '0;
        x_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == CW'(i)) begin
                w_sel = w[i];
                x_sel = x_q[i];
            end
        end
        prod = {{(XW + 1){w_sel[WW-1]}}, w_sel} * {{WW{1'b0}}, x_sel};
        acc_next = acc + {{(AW - PW){prod[PW-1]}}, prod};
    end

    assign busy = ~in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            bias      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_class <= 1'b0;
            out_sum   <= '0;
            for (int i = 0; i < N; i++) begin
                w[i]   <= '0;
                x_q[i] <= '0;
            end
`ifdef PERCEPTRON_TRAIN_EN
            target_q <= 1'b0;
            train_q  <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (wr_en) begin
                        for (int i = 0; i < N; i++) begin
                            if (wr_addr == CW'(i)) w[i] <= wr_data;
                        end
                        if (wr_addr == CW'(N)) bias <= wr_data;
                    end
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < N; i++) begin
                            x_q[i] <= in_x[i*XW +: XW];
                        end
`ifdef PERCEPTRON_TRAIN_EN
                        target_q <= in_target;
                        train_q  <= in_train;
`endif
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    if (cnt == '0) acc <= {{(AW - WW){bias[WW-1]}}, bias};
                    else acc <= acc_next;
                    if (cnt == CW'(N)) begin
                        out_valid <= 1'b1;
                        out_sum   <= acc_next;
                        out_class <= ~acc_next[AW-1];
                        state     <= DECIDE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DECIDE: begin
                    cnt <= '0;
`ifdef PERCEPTRON_TRAIN_EN
                    if (train_q && (out_class != target_q)) begin
                        state <= UPDATE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
`else
                    in_ready <= 1'b1;
                    state    <= IDLE;
`endif
                end
`ifdef PERCEPTRON_TRAIN_EN
                UPDATE: begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt == CW'(i)) w[i] <= sat_step(w_sel, x_sel, target_q);
                    end
                    if (cnt == CW'(N)) begin
                        bias     <= sat_step(bias, XW'(1), target_q);
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/perceptron_learner.md
# perceptron_learner

Parametrised, trainable single-layer perceptron core. It classifies an N-element vector of unsigned features against signed stored weights plus a bias, using one multiply-accumulate per cycle. It can optionally apply the perceptron learning rule online when a labelled training sample misclassifies. It sits behind the top-level pin wrapper, which maps switch/bidirectional inputs to `in_x` and drives `out_class` to the display.

## Interface
- `N` — default 8 — number of features.
- `XW` — default 8 — feature width, unsigned.
- `WW` — default 8 — weight and bias width, signed two's complement.
- `AW` — derived, XW+WW+$clog2(N+1)+1 — accumulator width; not user-set.
- `clk` in 1 — the single clock; all logic is on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — sample offered.
- `in_ready` out 1 — core can accept a sample.
- `in_x` in N*XW — features; feature i is at bits [i*XW +: XW].
- `in_target` in 1 — label for training.
- `in_train` in 1 — sample is a training sample.
- `wr_en` in 1 — weight/bias write strobe.
- `wr_addr` in $clog2(N+1) — 0..N-1 selects a weight; N selects the bias.
- `wr_data` in WW — value to write.
- `out_valid` out 1 — one-cycle result strobe.
- `out_class` out 1 — classification result.
- `out_sum` out AW — signed dot product plus bias.
- `busy` out 1 — equals !in_ready.

## Operation
- **FSM states:** IDLE, MAC, DECIDE, UPDATE.
- **IDLE**
  - in_ready=1.
  - Accept on in_valid&&in_ready: latch in_x, in_target and in_train; go to MAC.
- **MAC** (N+1 cycles, step k=0..N)
  - Step 0: acc ← sign-extended bias.
  - Step k≥1: acc ← acc + w[k-1]·x[k-1] (signed × zero-extended).
  - AW bits cannot overflow.
- **DECIDE** (1 cycle)
  - out_valid=1, out_sum=acc, out_class=(acc ≥ 0).
  - If training is compiled in, in_train was latched high, and out_class≠target: go to UPDATE.
  - Otherwise go to IDLE.
- **UPDATE** (N+1 cycles, step j=0..N)
  - Step j<N: w[j] ← sat(w[j] ± x[j]).
  - Step N: bias ← sat(bias ± 1).
  - The sign is + when target=1 and − when target=0.
  - sat() clamps to [−2^(WW−1), 2^(WW−1)−1].
  - Then go to IDLE.
- **Writes**
  - Honoured only in IDLE; silently dropped in any other state.
  - wr_addr > N is ignored.
  - Writes apply at the clock edge.
- **Simultaneous accept and write:** the write takes effect, and the MAC uses the new value, because weights are read from MAC step 0 onward.
- **Output holding:** out_sum and out_class hold their values until the next DECIDE. out_valid is high only in DECIDE.

## Timing
- **Reset values:** state IDLE, all weights and bias 0, out_valid 0, out_class 0, out_sum 0, in_ready 0 while rst is high and 1 on the first cycle after release, busy = !in_ready.
- **Latency:** with the accept at cycle 0, out_valid is high at cycle N+2.
- **Throughput:**
  - No update: in_ready returns at cycle N+3, one sample per N+3 cycles.
  - With update: in_ready returns at cycle 2N+4.
- **Reset mid-operation:** rst in any state aborts. No out_valid is produced for the aborted sample, and the weights return to 0, including any partially applied update.
- **No pipelining:** in_valid while busy is not accepted; the upstream block holds it.

## Configuration
- Macro: `PERCEPTRON_TRAIN_EN`.
- **Defined:** the UPDATE state, saturating adders and in_train/in_target paths are present, as described above.
- **Undefined:**
  - UPDATE is not built; in_train and in_target are ignored.
  - DECIDE always returns to IDLE, so each sample takes N+3 cycles.
  - Weights change only through wr_en.

## Test plan
All scenarios use N=4, XW=8, WW=8.
- **Reset defaults:** reset, then x={1,2,3,4} without training → out_valid at cycle 6, out_sum=0, out_class=1, weights still 0.
- **Inference:** write w={1,−2,3,−4} and bias=−1, then x={10,1,1,1} → out_sum=6, out_class=1; x={0,1,0,1} → out_sum=−7, out_class=0.
- **Training update** (macro defined): zero weights, x={5,0,0,0}, target 0, train 1 → out_class=1 (mismatch); afterwards w0=−5, bias=−1, in_ready back at cycle 12. Repeating the same x without training → out_sum=−26, out_class=0.
- **Saturation:** w={100,−128,0,0}, bias 0, x={50,100,0,0}, target 1, train 1 → out_sum=−7800, class 0; afterwards w0=127 (clamped), w1=−28, bias=1.
- **Write and accept rules:** wr_en during MAC is dropped (readback via the next inference is unchanged). wr_en to w0=2 in the same cycle as accepting x={3,0,0,0} → out_sum=6.
- **Reset and compile-out:** rst asserted at MAC step 2 → no out_valid, in_ready=1 the cycle after release, weights 0. With the macro undefined, a training mismatch leaves the weights unchanged and in_ready returns at cycle 7.
